// File: rtl/enemy_life_ctrl.sv
// Lifecycle controller for a pool of NUM enemy slots: spawn, hit flash, life, destruction animation.
// Optional score accumulator enabled by defining ENEMY_SCORE_EN.
module enemy_life_ctrl #(
    parameter int unsigned NUM            = 4,
    parameter int unsigned NUM_W          = 2,
    parameter int unsigned LIFE           = 8,
    parameter int unsigned LIFE_W         = 4,
    parameter int unsigned DOWN_FRAMES    = 3,
    parameter int unsigned SEL_W          = 3,
    parameter int unsigned TICK_CYCLES    = 1000000,
    parameter int unsigned TICK_W         = 20,
    parameter int unsigned SCORE_PER_KILL = 10,
    parameter int unsigned SCORE_W        = 16
) (
    input  logic               clk_vga,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               trigger_i,
    input  logic [NUM_W-1:0]   trigger_idx_i,
    input  logic [NUM_W-1:0]   curr_idx_i,
    input  logic               hit_bullet_i,
    input  logic               hit_me_i,
    output logic [NUM-1:0]     disappear_o,
    output logic               sprite_vali_o,
    output logic [SEL_W-1:0]   sprite_sel_o,
    output logic [NUM-1:0]     kill_o,
    output logic [NUM_W:0]     alive_cnt_o,
    output logic [SCORE_W-1:0] score_o
);

    typedef enum logic [1:0] {StIdle, StNormal, StHit, StDown} state_e;

    state_e            state_q [NUM];
    state_e            state_d [NUM];
    logic [LIFE_W-1:0] life_q  [NUM];
    logic [LIFE_W-1:0] life_d  [NUM];
    logic [SEL_W-1:0]  frame_q [NUM];
    logic [SEL_W-1:0]  frame_d [NUM];
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic              tick;
    logic [NUM-1:0]    kill_q, kill_d, disappear_q, disappear_d;
    logic [NUM_W:0]    alive_q, alive_d;

    always_comb begin
        tick  = en_i && (cnt_q == TICK_W'(TICK_CYCLES - 1));
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tick ? '0 : cnt_q + TICK_W'(1);
        end
    end

    // Slot indices >= NUM never match any i, so out-of-range requests drop out here.
    always_comb begin
        for (int i = 0; i < NUM; i++) begin
            state_d[i] = state_q[i];
            life_d[i]  = life_q[i];
            frame_d[i] = frame_q[i];
            kill_d[i]  = 1'b0;
            if (en_i) begin
                unique case (state_q[i])
                    StIdle: begin
                        if (trigger_i && (trigger_idx_i == NUM_W'(i))) begin
                            state_d[i] = StNormal;
                            life_d[i]  = LIFE_W'(LIFE);
                            frame_d[i] = '0;
                        end
                    end
                    StNormal: begin
                        if ((curr_idx_i == NUM_W'(i)) && (hit_bullet_i || hit_me_i)) begin
                            state_d[i] = StHit;
                            if (hit_me_i) begin
                                life_d[i] = '0;
                            end else if (life_q[i] != '0) begin
                                life_d[i] = life_q[i] - LIFE_W'(1);
                            end
                        end
                    end
                    StHit: begin
                        if (tick) begin
                            if (life_q[i] == '0) begin
                                state_d[i] = StDown;
                                frame_d[i] = '0;
                                kill_d[i]  = 1'b1;
                            end else begin
                                state_d[i] = StNormal;
                            end
                        end
                    end
                    StDown: begin
                        if (tick) begin
                            if (frame_q[i] == SEL_W'(DOWN_FRAMES - 1)) begin
                                state_d[i] = StIdle;
                            end else begin
                                frame_d[i] = frame_q[i] + SEL_W'(1);
                            end
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        alive_d     = '0;
        disappear_d = '0;
        for (int i = 0; i < NUM; i++) begin
            disappear_d[i] = (state_q[i] == StIdle);
            alive_d = alive_d + (NUM_W+1)'((state_q[i] == StNormal) || (state_q[i] == StHit));
        end
    end

    always_comb begin
        sprite_vali_o = 1'b0;
        sprite_sel_o  = '0;
        for (int i = 0; i < NUM; i++) begin
            if (curr_idx_i == NUM_W'(i)) begin
                case (state_q[i])
                    StNormal: sprite_vali_o = 1'b1;
                    StHit: begin
                        sprite_vali_o = 1'b1;
                        sprite_sel_o  = SEL_W'(1);
                    end
                    StDown: begin
                        sprite_vali_o = 1'b1;
                        sprite_sel_o  = SEL_W'(2) + frame_q[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            kill_q      <= '0;
            disappear_q <= '1;
            alive_q     <= '0;
            for (int i = 0; i < NUM; i++) begin
                state_q[i] <= StIdle;
                life_q[i]  <= LIFE_W'(LIFE);
                frame_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            disappear_q <= disappear_d;
            alive_q     <= alive_d;
            for (int i = 0; i < NUM; i++) begin
                state_q[i] <= state_d[i];
                life_q[i]  <= life_d[i];
                frame_q[i] <= frame_d[i];
            end
        end
    end

    assign disappear_o = disappear_q;
    assign kill_o      = kill_q;
    assign alive_cnt_o = alive_q;

`ifdef ENEMY_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   score_sum;
    int unsigned        n_kill;

    // Score lands together with the kill_o pulse it accounts for.
    always_comb begin
        n_kill = 0;
        for (int i = 0; i < NUM; i++) begin
            if (kill_d[i]) begin
                n_kill = n_kill + 1;
            end
        end
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(n_kill * SCORE_PER_KILL);
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score_o = score_q;
`else
    assign score_o = '0;
`endif

endmodule
